// File: rtl/radio_frame_pkg.sv
// Shared types and constants for the radio serial-link frame sequencer.
// Holds the FSM state enum, word geometry, CRC-8 polynomial and a one-bit CRC step helper.
package radio_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CNT,
        ST_DATA,
        ST_CRC
    } state_t;

    localparam int         WORD_BITS         = 8;
    localparam logic [7:0] CRC8_POLY         = 8'h07;
    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

    // MSB-first CRC-8 update for one transmitted bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/radio_frame_sequencer_crc8_serial.sv
// Serial CRC-8 accumulator (poly 0x07, init 0, no reflection); one bit per valid cycle.
// Synchronous clear has priority over accumulation.
module crc8_serial
    import radio_frame_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       valid,
    input  logic       data_bit,
    output logic [7:0] crc
);

    always_ff @(posedge clk) begin
        if (clear) begin
            crc <= '0;
        end else if (valid) begin
            crc <= crc8_step(crc, data_bit);
        end
    end

endmodule

// File: rtl/radio_frame_sequencer.sv
// Frames sample words onto a single-wire LSB-first stream: sync word, frame count, data words.
// Optional CRC-8 trailer word when RADIO_FRAME_CRC_EN is defined.
module radio_frame_sequencer
    import radio_frame_pkg::*;
#(
    parameter int         FRAME_WORDS = 64,
    parameter logic [7:0] SYNC_WORD   = DEFAULT_SYNC_WORD
) (
    input  logic       SYS_CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [1:0] R0_I,
    input  logic [1:0] R0_Q,
    input  logic [1:0] R1_I,
    input  logic [1:0] R1_Q,
    output logic       DATA_OUT,
    output logic       SYNC,
    output logic       MISC,
    output logic [7:0] FRAME_CNT
);

    localparam int WCW = $clog2(FRAME_WORDS) + 1;

    state_t         state;
    state_t         state_next;
    logic [2:0]     bit_cnt;
    logic [WCW-1:0] word_cnt;
    logic [7:0]     shift;
    logic [7:0]     load_word;
    logic [7:0]     sample;
    logic           load;
    logic           frame_done;
    logic           last_bit;
    logic           last_data;

`ifdef RADIO_FRAME_CRC_EN
    logic [7:0] crc_q;
    logic [7:0] trailer;

    // Bits of the CNT and DATA words feed the CRC exactly as they leave the wire.
    crc8_serial u_crc (
        .clk      (SYS_CLK),
        .clear    (RST || (state == ST_HDR)),
        .valid    ((state == ST_CNT) || (state == ST_DATA)),
        .data_bit (shift[0]),
        .crc      (crc_q)
    );

    // The final data bit is folded in on the same edge that loads the trailer.
    assign trailer = crc8_step(crc_q, shift[0]);
`endif

    assign sample    = {R0_I, R0_Q, R1_I, R1_Q};
    assign last_bit  = (bit_cnt == 3'(WORD_BITS - 1));
    assign last_data = (word_cnt == WCW'(FRAME_WORDS - 1));

    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_word  = '0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (EN) begin
                    state_next = ST_HDR;
                    load       = 1'b1;
                    load_word  = SYNC_WORD;
                end
            end
            ST_HDR: begin
                if (last_bit) begin
                    state_next = ST_CNT;
                    load       = 1'b1;
                    load_word  = FRAME_CNT;
                end
            end
            ST_CNT: begin
                if (last_bit) begin
                    state_next = ST_DATA;
                    load       = 1'b1;
                    load_word  = sample;
                end
            end
            ST_DATA: begin
                if (last_bit) begin
                    if (!last_data) begin
                        load      = 1'b1;
                        load_word = sample;
                    end else begin
`ifdef RADIO_FRAME_CRC_EN
                        state_next = ST_CRC;
                        load       = 1'b1;
                        load_word  = trailer;
`else
                        frame_done = 1'b1;
`endif
                    end
                end
            end
`ifdef RADIO_FRAME_CRC_EN
            ST_CRC: begin
                if (last_bit) begin
                    frame_done = 1'b1;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
        // Back-to-back frames: the next header starts on the very edge the frame ends.
        if (frame_done) begin
            if (EN) begin
                state_next = ST_HDR;
                load       = 1'b1;
                load_word  = SYNC_WORD;
            end else begin
                state_next = ST_IDLE;
            end
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            shift     <= '0;
            FRAME_CNT <= '0;
        end else begin
            state <= state_next;
            if (state_next == ST_IDLE) begin
                bit_cnt <= '0;
                shift   <= '0;
            end else begin
                bit_cnt <= load ? 3'd0 : bit_cnt + 3'd1;
                shift   <= load ? load_word : {1'b0, shift[7:1]};
            end
            if (state_next != ST_DATA) begin
                word_cnt <= '0;
            end else if (state == ST_DATA && last_bit) begin
                word_cnt <= word_cnt + WCW'(1);
            end
            if (frame_done) begin
                FRAME_CNT <= FRAME_CNT + 8'd1;
            end
        end
    end

    assign DATA_OUT = shift[0];
    assign SYNC     = (state == ST_HDR);
    assign MISC     = (state != ST_IDLE);

endmodule

// File: tb/tb_radio_frame_sequencer.sv
// Randomized bench with a frame-level reference model plus literal checks of the worked examples.
module tb_radio_frame_sequencer;

    localparam int FW = 4;
`ifdef RADIO_FRAME_CRC_EN
    localparam int NWORDS = FW + 3;
`else
    localparam int NWORDS = FW + 2;
`endif
    localparam int FLEN = NWORDS * 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [1:0] r0_i = '0, r0_q = '0, r1_i = '0, r1_q = '0;
    logic       data_out, sync, misc;
    logic [7:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    radio_frame_sequencer #(.FRAME_WORDS(FW), .SYNC_WORD(8'hA5)) dut (
        .SYS_CLK   (clk),
        .RST       (rst),
        .EN        (en),
        .R0_I      (r0_i),
        .R0_Q      (r0_q),
        .R1_I      (r1_i),
        .R1_Q      (r1_q),
        .DATA_OUT  (data_out),
        .SYNC      (sync),
        .MISC      (misc),
        .FRAME_CNT (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] crc_bytes(input logic [7:0] q[$]);
        logic [7:0] c;
        c = 8'h00;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                if (c[7] ^ q[i][b]) c = (c << 1) ^ 8'h07;
                else                c = c << 1;
            end
        end
        return c;
    endfunction

    // Frame-level model: position k within the frame, word index k/8, bit k%8.
    bit         m_active = 1'b0;
    int         m_k = 0;
    logic [7:0] m_word = '0;
    logic [7:0] m_cnt = '0;
    logic [7:0] m_payload[$];
    bit         cmp_on = 1'b0;

    always @(posedge clk) begin
        int w;
        if (rst) begin
            m_active = 1'b0;
            m_k      = 0;
            m_cnt    = '0;
            m_word   = '0;
        end else if (!m_active) begin
            if (en) begin
                m_active = 1'b1;
                m_k      = 0;
                m_word   = 8'hA5;
            end
        end else begin
            m_k++;
            if (m_k == FLEN) begin
                m_cnt++;
                if (en) begin
                    m_k    = 0;
                    m_word = 8'hA5;
                end else begin
                    m_active = 1'b0;
                end
            end else if (m_k % 8 == 0) begin
                w = m_k / 8;
                if (w == 1) begin
                    m_word = m_cnt;
                    m_payload.delete();
                    m_payload.push_back(m_word);
                end else if (w <= FW + 1) begin
                    m_word = {r0_i, r0_q, r1_i, r1_q};
                    m_payload.push_back(m_word);
                end else begin
                    m_word = crc_bytes(m_payload);
                end
            end
        end
        cmp_on = 1'b1;
    end

    always @(negedge clk) begin
        logic exp_d;
        if (cmp_on) begin
            exp_d = m_active ? m_word[m_k % 8] : 1'b0;
            chk("model_cmp {data,sync,misc,cnt}",
                {21'd0, data_out, sync, misc, frame_cnt},
                {21'd0, exp_d, m_active && (m_k < 8), m_active, m_cnt});
        end
    end

    logic cap_d[$];
    int   cap_s_first8, cap_s_total, cap_m_total;
    bit   rand_in = 1'b0;

    task automatic capture(input int n);
        cap_d.delete();
        cap_s_first8 = 0;
        cap_s_total  = 0;
        cap_m_total  = 0;
        for (int i = 0; i < n; i++) begin
            cap_d.push_back(data_out);
            if (sync && i < 8) cap_s_first8++;
            if (sync) cap_s_total++;
            if (misc) cap_m_total++;
            if (rand_in) {r0_i, r0_q, r1_i, r1_q} = 8'($urandom);
            @(negedge clk);
        end
    endtask

    function automatic logic [7:0] cap_byte(input int base);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = cap_d[base + b];
        return v;
    endfunction

    logic [47:0] exp48;
    logic [47:0] got48;
    logic [7:0]  pl[$];
    logic [7:0]  cw;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_data_out", {31'd0, data_out}, 32'd0);
        chk("reset_sync", {31'd0, sync}, 32'd0);
        chk("reset_misc", {31'd0, misc}, 32'd0);
        chk("reset_frame_cnt", {24'd0, frame_cnt}, 32'd0);

        // Single frame with constant word 0xC6.
        rst = 1'b0;
        {r0_i, r0_q, r1_i, r1_q} = 8'hC6;
        @(negedge clk); en = 1'b1;
        @(negedge clk); en = 1'b0;
        capture(FLEN);
        exp48 = {8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'hA5};
        for (int i = 0; i < 48; i++) got48[i] = cap_d[i];
        chk("single_stream_lo", got48[31:0], exp48[31:0]);
        chk("single_stream_hi", {16'd0, got48[47:32]}, {16'd0, exp48[47:32]});
        chk("single_sync_first8", cap_s_first8, 8);
        chk("single_sync_total", cap_s_total, 8);
        chk("single_misc_len", cap_m_total, FLEN);
        chk("single_idle_after", {31'd0, misc}, 32'd0);
        chk("single_frame_cnt", {24'd0, frame_cnt}, 32'd1);

        // Reset and enable together: reset wins; then back-to-back frames.
        rst = 1'b1; en = 1'b1;
        @(negedge clk);
        chk("rst_wins_misc", {31'd0, misc}, 32'd0);
        chk("rst_wins_cnt", {24'd0, frame_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rand_in = 1'b1;
        capture(3 * FLEN);
        for (int f = 0; f < 3; f++)
            chk($sformatf("b2b_count_word%0d", f), {24'd0, cap_byte(f * FLEN + 8)}, f);
        chk("b2b_no_gap", cap_m_total, 3 * FLEN);
        chk("b2b_sync_total", cap_s_total, 24);
        en = 1'b0;
        capture(FLEN);
        chk("b2b_last_frame_full", cap_m_total, FLEN);
        chk("b2b_idle_after", {31'd0, misc}, 32'd0);
        chk("b2b_frame_cnt", {24'd0, frame_cnt}, 32'd4);

        // Random enable and occasional reset, model-checked every cycle.
        for (int i = 0; i < 2000; i++) begin
            {r0_i, r0_q, r1_i, r1_q} = 8'($urandom);
            en  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0; en = 1'b0;
        repeat (FLEN + 2) @(negedge clk);

        // Make sure FRAME_CNT is nonzero, then reset on bit 3 of data word 2.
        en = 1'b1;
        @(negedge clk); en = 1'b0;
        capture(35);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outputs", {28'd0, data_out, sync, misc, 1'b0}, 32'd0);
        chk("midrst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_still_idle", {31'd0, misc}, 32'd0);
        en = 1'b1;
        @(negedge clk); en = 1'b0;
        capture(FLEN);
        chk("midrst_next_count_word", {24'd0, cap_byte(8)}, 32'd0);

        // Counter wrap over 257 frames.
        rst = 1'b1; en = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        for (int f = 0; f < 257; f++) begin
            if (f == 256) en = 1'b0;
            capture(FLEN);
            cw = cap_byte(8);
            if (f == 255) chk("wrap_count_word_256th", {24'd0, cw}, 32'hFF);
            if (f == 256) chk("wrap_count_word_257th", {24'd0, cw}, 32'h00);
        end
        chk("wrap_idle_after", {31'd0, misc}, 32'd0);
        chk("wrap_frame_cnt", {24'd0, frame_cnt}, 32'd1);

`ifdef RADIO_FRAME_CRC_EN
        rand_in = 1'b0;
        {r0_i, r0_q, r1_i, r1_q} = 8'h00;
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; en = 1'b1;
        @(negedge clk); en = 1'b0;
        capture(FLEN);
        chk("crc_zero_trailer", {24'd0, cap_byte((FW + 2) * 8)}, 32'h00);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; en = 1'b1;
        @(negedge clk); en = 1'b0;
        capture(15);
        r1_q = 2'b01;
        capture(1);
        r1_q = 2'b00;
        capture(FLEN - 16);
        pl.delete();
        pl.push_back(8'h00);
        pl.push_back(8'h01);
        for (int i = 1; i < FW; i++) pl.push_back(8'h00);
        chk("crc_flip_trailer", {24'd0, cap_byte((FW + 2) * 8)}, {24'd0, crc_bytes(pl)});
        chk("crc_flip_nonzero", {31'd0, (cap_byte((FW + 2) * 8) != 8'h00)}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/radio_frame_sequencer.md
# radio_frame_sequencer

Frame controller for the radio serial link. It sequences the single-wire `DATA_OUT` stream into framed packets: a sync word, a frame counter and `FRAME_WORDS` packed I/Q sample words, plus an optional CRC-8 trailer. It captures one packed sample from both radios per word slot and drives `SYNC` and `MISC` as frame markers for the downstream receiver. It sits between the radio sample pins and the serial output, all in the `SYS_CLK` domain.

## Interface
- `FRAME_WORDS`, default 64: data words per frame; legal range 1..256.
- `SYNC_WORD`, default 8'hA5: header word.
- `SYS_CLK` in 1: the single clock, 16.368 MHz; also clocks both radios.
- `RST` in 1: reset; synchronous, active-high.
- `EN` in 1: stream enable, level-sensitive.
- `R0_I`, `R0_Q`, `R1_I`, `R1_Q` in 2 each: radio sample bits, synchronous to `SYS_CLK`.
- `DATA_OUT` out 1: serial bit stream, registered, LSB-first.
- `SYNC` out 1: high for the 8 bit-times of the header word.
- `MISC` out 1: frame active; high in every state except IDLE.
- `FRAME_CNT` out 8: number of completed frames, mod 256.

## Operation
- States:
  - IDLE
  - HDR: sends `SYNC_WORD`.
  - CNT: sends `FRAME_CNT`.
  - DATA: sends `FRAME_WORDS` words.
  - CRC: present only with the macro.
- Each word occupies exactly 8 `SYS_CLK` cycles. A 3-bit bit counter runs 0..7; bit 7 is the word boundary.
- The shift register is loaded at each word boundary and shifts right once per cycle. `DATA_OUT` is shift[0].
- Packed data word = {R0_I, R0_Q, R1_I, R1_Q}, bits 7..0. The inputs are sampled on the same edge that loads the word, so there is one sample per 8 cycles.
- Transitions:
  - IDLE → HDR on the first edge where `EN` = 1.
  - HDR → CNT and CNT → DATA after 8 cycles each.
  - DATA → CRC (macro) or end-of-frame after word `FRAME_WORDS`-1.
  - At end-of-frame: `FRAME_CNT` increments (255 wraps to 0). Next state is HDR if `EN` = 1 on that edge, otherwise IDLE.
- Deasserting `EN` mid-frame has no effect until the frame completes. Frames are never truncated except by `RST`.
- Frames run back-to-back with no idle bit between them.
- In IDLE: `DATA_OUT` = 0, bit counter held at 0, word counter held at 0.
- The word counter is `$clog2(FRAME_WORDS)+1` bits wide and has no wrap inside a frame.

## Timing
- Reset values: `DATA_OUT` = 0, `SYNC` = 0, `MISC` = 0, `FRAME_CNT` = 0, state IDLE, all counters 0.
- `RST` asserted mid-frame: on the next edge all of the above apply and the partial frame is abandoned.
- `EN` sampled high at edge t:
  - Header bit 0 appears on `DATA_OUT` after edge t.
  - `SYNC` and `MISC` rise after the same edge.
- `SYNC` falls after edge t+8, together with the first CNT bit.
- `FRAME_CNT` updates on the last-bit edge of the frame. The CNT word carries the pre-increment value.
- Frame length is (2+`FRAME_WORDS`)×8 cycles without CRC, or (3+`FRAME_WORDS`)×8 cycles with CRC.
- `RST` and `EN` high on the same edge: reset wins.

## Configuration
- `RADIO_FRAME_CRC_EN` defined:
  - Adds the CRC state and one trailer word per frame.
  - CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR.
  - Computed serially over the transmitted bits of the CNT and DATA words in wire order.
  - The CRC register clears at each HDR.
  - The trailer is sent LSB-first like every other word.
- Not defined: no CRC logic; DATA → end-of-frame directly.

## Structure
- Package `radio_frame_pkg` holds:
  - The state enum.
  - `WORD_BITS` = 8.
  - `CRC8_POLY` = 8'h07.
  - The default `SYNC_WORD`.
- Sub-module `crc8_serial`:
  - Ports: clk, sync clear, bit-valid, bit in, 8-bit CRC out.
  - Instantiated only under `RADIO_FRAME_CRC_EN`.

## Test plan
- Reset: `RST` high for 3 cycles → `DATA_OUT`=0, `SYNC`=0, `MISC`=0, `FRAME_CNT`=0.
- Single frame:
  - Setup: `FRAME_WORDS`=4; one-cycle `EN` pulse; inputs R0_I=11, R0_Q=00, R1_I=01, R1_Q=10 (word 8'hC6).
  - Expected: bits 1,0,1,0,0,1,0,1 with `SYNC` high for 8 cycles; then 8 zeros (count 0); then 4× (0,1,1,0,0,0,1,1).
  - `MISC` stays high for exactly 48 cycles, then IDLE; `FRAME_CNT`=1.
- Back-to-back: `EN` held high, `FRAME_WORDS`=4 → contiguous frames with count words 0x00, 0x01, 0x02 and no gap cycles.
- Wrap: 257 frames → the 256th count word is 0xFF, the 257th is 0x00, `FRAME_CNT` shows 0x01.
- Reset mid-DATA: `RST` on bit 3 of data word 2 → next cycle all outputs 0, IDLE. The next frame's count word is 0x00.
- CRC (macro defined): all-zero inputs, count 0 → trailer 0x00. Flipping R1_Q bit 0 in one word → trailer matches the bench's serial CRC-8 model, which must be nonzero.
